// File: rtl/stereo_sample_fifo.sv
// ---------------------------------------------------------------------------
// stereo_sample_fifo
//
// Stereo sample buffer that sits between the synth voice/mixer output and
// audio_mux. The synth pushes one left/right pair per wr_en. audio_mux pops
// the left and right channels independently. Each head word is presented
// show-ahead, so audio_mux can register it in the same cycle as its read.
//
// Parameters
//   FIFO_WIDTH     log2 of the per-channel depth
//   AUD_BIT_DEPTH  sample width in bits
//   LOW_WATERMARK  fill_req threshold in words (watermark build only)
//
// Optional feature macro: SAMPLE_FIFO_WATERMARK_EN
//   defined   : fill_req is a registered "please refill" request
//   undefined : fill_req is tied low
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   flush                     synchronous clear of both channels
//   wr_en, wr_ldata, wr_rdata push one L/R pair
//   l_read, r_read            pop the left / right head
//   clr_flags                 clear the sticky overflow/underflow flags
//   lsound_fifo, rsound_fifo  show-ahead head words (0 when empty)
//   l_level, r_level          per-channel occupancy, 0..2**FIFO_WIDTH
//   full, l_empty, r_empty    status
//   overflow, underflow       sticky error flags
//   fill_req                  level below the watermark (feature only)
// ---------------------------------------------------------------------------
module stereo_sample_fifo #(
  parameter int FIFO_WIDTH    = 6,
  parameter int AUD_BIT_DEPTH = 24,
  parameter int LOW_WATERMARK = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [AUD_BIT_DEPTH-1:0] wr_ldata,
  input  logic [AUD_BIT_DEPTH-1:0] wr_rdata,
  input  logic                     l_read,
  input  logic                     r_read,
  input  logic                     clr_flags,
  output logic [AUD_BIT_DEPTH-1:0] lsound_fifo,
  output logic [AUD_BIT_DEPTH-1:0] rsound_fifo,
  output logic [FIFO_WIDTH:0]      l_level,
  output logic [FIFO_WIDTH:0]      r_level,
  output logic                     full,
  output logic                     l_empty,
  output logic                     r_empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     fill_req
);

  localparam int DEPTH = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] DEPTH_LVL = {1'b1, {FIFO_WIDTH{1'b0}}};
  localparam logic [FIFO_WIDTH:0] ZERO_LVL  = '0;
  localparam logic [FIFO_WIDTH:0] ONE_LVL   = {{FIFO_WIDTH{1'b0}}, 1'b1};

  logic [AUD_BIT_DEPTH-1:0] mem_l [DEPTH];
  logic [AUD_BIT_DEPTH-1:0] mem_r [DEPTH];

  // Both channels are always written as a pair, so one write pointer serves both.
  logic [FIFO_WIDTH-1:0] wr_ptr;
  logic [FIFO_WIDTH-1:0] l_rd_ptr;
  logic [FIFO_WIDTH-1:0] r_rd_ptr;

  logic push_ok;
  logic l_pop_ok;
  logic r_pop_ok;
  logic overflow_evt;
  logic underflow_evt;
  logic [FIFO_WIDTH:0] l_level_nxt;
  logic [FIFO_WIDTH:0] r_level_nxt;

  assign l_empty = (l_level == ZERO_LVL);
  assign r_empty = (r_level == ZERO_LVL);
  // Levels never exceed the depth, so "either at depth" is "the larger one at depth".
  assign full    = (l_level == DEPTH_LVL) || (r_level == DEPTH_LVL);

  // Acceptance uses start-of-cycle status only: a same-cycle pop never makes
  // room for a push, and a same-cycle push never feeds a pop.
  assign push_ok       = wr_en && !full && !flush;
  assign l_pop_ok      = l_read && !l_empty && !flush;
  assign r_pop_ok      = r_read && !r_empty && !flush;
  assign overflow_evt  = wr_en && full;
  assign underflow_evt = (l_read && l_empty) || (r_read && r_empty);

  assign lsound_fifo = l_empty ? '0 : mem_l[l_rd_ptr];
  assign rsound_fifo = r_empty ? '0 : mem_r[r_rd_ptr];

  always_comb begin
    l_level_nxt = l_level;
    r_level_nxt = r_level;
    if (flush) begin
      l_level_nxt = ZERO_LVL;
      r_level_nxt = ZERO_LVL;
    end else begin
      if (push_ok && !l_pop_ok)      l_level_nxt = l_level + ONE_LVL;
      else if (!push_ok && l_pop_ok) l_level_nxt = l_level - ONE_LVL;
      if (push_ok && !r_pop_ok)      r_level_nxt = r_level + ONE_LVL;
      else if (!push_ok && r_pop_ok) r_level_nxt = r_level - ONE_LVL;
    end
  end

  // Sample storage has no reset; contents are only visible through a level > 0.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_l[wr_ptr] <= wr_ldata;
      mem_r[wr_ptr] <= wr_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      l_rd_ptr <= '0;
      r_rd_ptr <= '0;
      l_level  <= '0;
      r_level  <= '0;
    end else begin
      l_level <= l_level_nxt;
      r_level <= r_level_nxt;
      if (flush) begin
        wr_ptr   <= '0;
        l_rd_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (push_ok)  wr_ptr   <= wr_ptr + 1'b1;
        if (l_pop_ok) l_rd_ptr <= l_rd_ptr + 1'b1;
        if (r_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // A new event in the same cycle as clr_flags keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (overflow_evt)   overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (underflow_evt)  underflow <= 1'b1;
      else if (clr_flags) underflow <= 1'b0;
    end
  end

`ifdef SAMPLE_FIFO_WATERMARK_EN
  localparam logic [FIFO_WIDTH:0] LOW_LVL = LOW_WATERMARK[FIFO_WIDTH:0];

  logic [FIFO_WIDTH:0] min_level_nxt;
  logic                full_nxt;

  assign min_level_nxt = (l_level_nxt < r_level_nxt) ? l_level_nxt : r_level_nxt;
  assign full_nxt      = (l_level_nxt == DEPTH_LVL) || (r_level_nxt == DEPTH_LVL);

  // Registered from next-state levels so fill_req lines up with l_level/r_level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fill_req <= 1'b0;
    else          fill_req <= (min_level_nxt < LOW_LVL) && !full_nxt;
  end
`else
  // The watermark is meaningless without the feature; keep it referenced.
  logic unused_watermark;
  assign unused_watermark = ^LOW_WATERMARK;
  assign fill_req         = 1'b0;
`endif

endmodule

// File: tb/tb_stereo_sample_fifo.sv
module tb_stereo_sample_fifo;

  localparam int FW    = 6;
  localparam int BD    = 24;
  localparam int LW    = 16;
  localparam int DEPTH = 1 << FW;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          wr_en;
  logic [BD-1:0] wr_ldata;
  logic [BD-1:0] wr_rdata;
  logic          l_read;
  logic          r_read;
  logic          clr_flags;
  logic [BD-1:0] lsound_fifo;
  logic [BD-1:0] rsound_fifo;
  logic [FW:0]   l_level;
  logic [FW:0]   r_level;
  logic          full;
  logic          l_empty;
  logic          r_empty;
  logic          overflow;
  logic          underflow;
  logic          fill_req;

  int tests_run = 0;
  int failures  = 0;
  bit check_en  = 0;

  stereo_sample_fifo #(
    .FIFO_WIDTH   (FW),
    .AUD_BIT_DEPTH(BD),
    .LOW_WATERMARK(LW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .wr_en      (wr_en),
    .wr_ldata   (wr_ldata),
    .wr_rdata   (wr_rdata),
    .l_read     (l_read),
    .r_read     (r_read),
    .clr_flags  (clr_flags),
    .lsound_fifo(lsound_fifo),
    .rsound_fifo(rsound_fifo),
    .l_level    (l_level),
    .r_level    (r_level),
    .full       (full),
    .l_empty    (l_empty),
    .r_empty    (r_empty),
    .overflow   (overflow),
    .underflow  (underflow),
    .fill_req   (fill_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: two sample queues plus flag bits.
  logic [BD-1:0] ql[$];
  logic [BD-1:0] qr[$];
  bit m_of, m_uf, m_fr;
  bit m_was_full, m_ev_of, m_ev_uf;
  logic [BD-1:0] m_drop;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ql.delete();
      qr.delete();
      m_of = 0;
      m_uf = 0;
      m_fr = 0;
    end else begin
      m_was_full = (ql.size() == DEPTH) || (qr.size() == DEPTH);
      m_ev_of    = wr_en && m_was_full;
      m_ev_uf    = (l_read && ql.size() == 0) || (r_read && qr.size() == 0);
      if (flush) begin
        ql.delete();
        qr.delete();
      end else begin
        if (l_read && ql.size() > 0) m_drop = ql.pop_front();
        if (r_read && qr.size() > 0) m_drop = qr.pop_front();
        if (wr_en && !m_was_full) begin
          ql.push_back(wr_ldata);
          qr.push_back(wr_rdata);
        end
      end
      if (m_ev_of) m_of = 1; else if (clr_flags) m_of = 0;
      if (m_ev_uf) m_uf = 1; else if (clr_flags) m_uf = 0;
`ifdef SAMPLE_FIFO_WATERMARK_EN
      m_fr = ((ql.size() < qr.size() ? ql.size() : qr.size()) < LW) &&
             !(ql.size() == DEPTH || qr.size() == DEPTH);
`else
      m_fr = 0;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset_n && check_en) begin
      checkOutput("m_lhead", 32'(lsound_fifo), ql.size() > 0 ? 32'(ql[0]) : 32'd0);
      checkOutput("m_rhead", 32'(rsound_fifo), qr.size() > 0 ? 32'(qr[0]) : 32'd0);
      checkOutput("m_llevel", 32'(l_level), 32'(ql.size()));
      checkOutput("m_rlevel", 32'(r_level), 32'(qr.size()));
      checkOutput("m_full", 32'(full), 32'((ql.size() == DEPTH) || (qr.size() == DEPTH)));
      checkOutput("m_lempty", 32'(l_empty), 32'(ql.size() == 0));
      checkOutput("m_rempty", 32'(r_empty), 32'(qr.size() == 0));
      checkOutput("m_overflow", 32'(overflow), 32'(m_of));
      checkOutput("m_underflow", 32'(underflow), 32'(m_uf));
      checkOutput("m_fill_req", 32'(fill_req), 32'(m_fr));
    end
  end

  // Drive one cycle of inputs, return 1 time unit after the consuming edge.
  task automatic applyStimulus(input bit wr, input logic [BD-1:0] ld, input logic [BD-1:0] rd,
                               input bit lr, input bit rr, input bit fl, input bit cl);
    wr_en     = wr;
    wr_ldata  = ld;
    wr_rdata  = rd;
    l_read    = lr;
    r_read    = rr;
    flush     = fl;
    clr_flags = cl;
    @(posedge clk);
    #1;
    wr_en = 0; l_read = 0; r_read = 0; flush = 0; clr_flags = 0;
  endtask

  task automatic pushPair(input logic [BD-1:0] ld, input logic [BD-1:0] rd);
    applyStimulus(1, ld, rd, 0, 0, 0, 0);
  endtask

  task automatic clearAll();
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
  endtask

  initial begin
    reset_n = 0; flush = 0; wr_en = 0; wr_ldata = 0; wr_rdata = 0;
    l_read = 0; r_read = 0; clr_flags = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_lhead", 32'(lsound_fifo), 32'd0);
    checkOutput("rst_lempty", 32'(l_empty), 32'd1);
    checkOutput("rst_rempty", 32'(r_empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_fill_req", 32'(fill_req), 32'd0);
    reset_n = 1;
    check_en = 1;
    @(posedge clk);
    #1;

    // Three pairs, then alternate reads
    for (int i = 1; i <= 3; i++) pushPair(BD'(i), BD'(32'h100000 + i));
    checkOutput("p3_llevel", 32'(l_level), 32'd3);
    for (int i = 1; i <= 3; i++) begin
      checkOutput("p3_lhead", 32'(lsound_fifo), 32'(i));
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      checkOutput("p3_rhead", 32'(rsound_fifo), 32'h100000 + 32'(i));
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
    end
    checkOutput("p3_lvl0", 32'(l_level), 32'd0);
    checkOutput("p3_empty", 32'({l_empty, r_empty}), 32'd3);
    checkOutput("p3_flags", 32'({overflow, underflow}), 32'd0);

    // Fill to depth, then one more push
    for (int i = 0; i < DEPTH; i++) pushPair(BD'(32'h200000 + i), BD'(32'h300000 + i));
    checkOutput("full_flag", 32'(full), 32'd1);
    checkOutput("full_of_pre", 32'(overflow), 32'd0);
    pushPair(24'hABCDEF, 24'hFEDCBA);
    checkOutput("full_of", 32'(overflow), 32'd1);
    checkOutput("full_level", 32'(l_level), 32'd64);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("drain_lhead", 32'(lsound_fifo), 32'h200000 + 32'(i));
      applyStimulus(0, 0, 0, 1, 1, 0, 0);
    end
    checkOutput("drain_lhead_end", 32'(lsound_fifo), 32'd0);
    checkOutput("drain_lempty", 32'(l_empty), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("clr_of", 32'(overflow), 32'd0);

    // Underflow
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("uf_flag", 32'(underflow), 32'd1);
    checkOutput("uf_head", 32'(lsound_fifo), 32'd0);
    checkOutput("uf_level", 32'(l_level), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("uf_clr", 32'(underflow), 32'd0);

    // Same-cycle push and pop at level 5, then mixed traffic
    for (int i = 0; i < 5; i++) pushPair(BD'(32'h400000 + i), BD'(32'h500000 + i));
    applyStimulus(1, 24'h400005, 24'h500005, 1, 0, 0, 0);
    checkOutput("pp_llevel", 32'(l_level), 32'd5);
    checkOutput("pp_rlevel", 32'(r_level), 32'd6);
    checkOutput("pp_lhead", 32'(lsound_fifo), 32'h400001);
    for (int i = 0; i < 200; i++)
      applyStimulus(1'($urandom_range(0, 1)), BD'(32'h600000 + i), BD'(32'h700000 + i),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    clearAll();
    checkOutput("flush_clr_lvl", 32'(l_level), 32'd0);

    // Flush with a concurrent push
    for (int i = 0; i < 10; i++) pushPair(BD'(32'h800000 + i), BD'(32'h900000 + i));
    checkOutput("fl_pre", 32'(r_level), 32'd10);
    applyStimulus(1, 24'h123456, 24'h654321, 0, 0, 1, 0);
    checkOutput("fl_llevel", 32'(l_level), 32'd0);
    checkOutput("fl_rlevel", 32'(r_level), 32'd0);
    checkOutput("fl_heads", 32'(lsound_fifo | rsound_fifo), 32'd0);
    checkOutput("fl_of", 32'(overflow), 32'd0);

    // Watermark threshold
    for (int i = 0; i < 15; i++) pushPair(BD'(i), BD'(i));
`ifdef SAMPLE_FIFO_WATERMARK_EN
    checkOutput("wm_15", 32'(fill_req), 32'd1);
`else
    checkOutput("wm_15_off", 32'(fill_req), 32'd0);
`endif
    pushPair(24'd15, 24'd15);
    checkOutput("wm_16", 32'(fill_req), 32'd0);

    // Asynchronous reset mid-operation
    applyStimulus(1, 24'hAAAAAA, 24'hBBBBBB, 0, 0, 0, 0);
    #2 reset_n = 0;
    #1;
    checkOutput("ar_level", 32'({l_level, r_level}), 32'd0);
    checkOutput("ar_heads", 32'(lsound_fifo | rsound_fifo), 32'd0);
    checkOutput("ar_empty", 32'({l_empty, r_empty}), 32'd3);
    @(posedge clk);
    #3 reset_n = 1;
    @(posedge clk);
    #1;
    applyStimulus(1, 24'h0000C1, 24'h0000C2, 1, 1, 0, 0);
    checkOutput("ar_after_lvl", 32'(l_level), 32'd1);
    checkOutput("ar_after_head", 32'(lsound_fifo), 32'h0000C1);
    checkOutput("ar_after_uf", 32'(underflow), 32'd1);

    @(negedge clk);
    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
